// File: rtl/pipe_alu.sv
// Multi-cycle ALU with a valid/ready handshake: single-cycle logic/arith/shift
// ops plus iterative shift-add multiply and restoring divide.
module pipe_alu #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] s2,
    output logic [15:0]      psw,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned LW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] hi, hi_nxt;
    logic [WIDTH-1:0] lo, lo_nxt;
    logic [WIDTH-1:0] bq, bq_nxt;
    logic [WIDTH-1:0] s_nxt, s2_nxt;
    logic [15:0]      psw_nxt;
    logic             ov_nxt, ir_nxt;

    logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
    logic [WIDTH-1:0] op_s, op_s2;
    logic [15:0]      op_psw;
    logic             op_cf, op_of, op_dz, op_il, op_zf, op_sf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_sh, div_trial;
    logic [WIDTH-1:0] div_hi, div_lo;

    // Single-cycle result and flags, computed straight from the accepted inputs
    always_comb begin
        op_s   = '0;
        op_s2  = '0;
        op_cf  = 1'b0;
        op_of  = 1'b0;
        op_dz  = 1'b0;
        op_il  = 1'b0;
        add_w  = {1'b0, a} + {1'b0, b};
        sub_w  = {1'b0, a} - {1'b0, b};
        shl_w  = {1'b0, a} << b[LW-1:0];
        shr_w  = {a, 1'b0} >> b[LW-1:0];
        case (mode)
            OP_ADD: begin
                op_s  = add_w[WIDTH-1:0];
                op_cf = add_w[WIDTH];
                op_of = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_s  = sub_w[WIDTH-1:0];
                op_cf = sub_w[WIDTH];
                op_of = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: op_s = a & b;
            OP_OR:  op_s = a | b;
            OP_XOR: op_s = a ^ b;
            OP_NOT: op_s = ~a;
            OP_SHL: begin
                op_s  = shl_w[WIDTH-1:0];
                op_cf = shl_w[WIDTH];
            end
            OP_SHR: begin
                op_s  = shr_w[WIDTH:1];
                op_cf = shr_w[0];
            end
            OP_MUL: ;
            OP_DIV: begin
                // only reaches the output path when the divisor is zero
                op_s  = '1;
                op_s2 = a;
                op_dz = 1'b1;
            end
            default: op_il = 1'b1;
        endcase
        op_zf  = (op_s == '0) && !op_dz && !op_il;
        op_sf  = op_s[WIDTH-1];
        op_psw = {10'b0, op_il, op_dz, op_of, op_sf, op_zf, op_cf};
    end

    // One shift-add multiply step and one restoring divide step on {hi, lo}
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
        mul_hi    = mul_sum[WIDTH:1];
        mul_lo    = {mul_sum[0], lo[WIDTH-1:1]};
        div_sh    = {hi, lo[WIDTH-1]};
        div_trial = div_sh - {1'b0, bq};
        if (!div_trial[WIDTH]) begin
            div_hi = div_trial[WIDTH-1:0];
            div_lo = {lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi = div_sh[WIDTH-1:0];
            div_lo = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        bq_nxt    = bq;
        s_nxt     = s;
        s2_nxt    = s2;
        psw_nxt   = psw;
        ov_nxt    = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    cnt_nxt = '0;
                    hi_nxt  = '0;
                    lo_nxt  = a;
                    bq_nxt  = b;
                    if (mode == OP_MUL) begin
                        state_nxt = MUL;
                    end else if ((mode == OP_DIV) && (b != '0)) begin
                        state_nxt = DIV;
                    end else begin
                        state_nxt = DONE;
                        s_nxt     = op_s;
                        s2_nxt    = op_s2;
                        psw_nxt   = op_psw;
                        ov_nxt    = 1'b1;
                    end
                end
            end
            MUL: begin
                hi_nxt  = mul_hi;
                lo_nxt  = mul_lo;
                cnt_nxt = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    s_nxt     = mul_lo;
                    s2_nxt    = mul_hi;
                    psw_nxt   = {10'b0, 1'b0, 1'b0, |mul_hi, mul_lo[WIDTH-1],
                                 ~|{mul_hi, mul_lo}, |mul_hi};
                    ov_nxt    = 1'b1;
                end
            end
            DIV: begin
                hi_nxt  = div_hi;
                lo_nxt  = div_lo;
                cnt_nxt = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nxt = DONE;
                    s_nxt     = div_lo;
                    s2_nxt    = div_hi;
                    psw_nxt   = {10'b0, 1'b0, 1'b0, 1'b0, div_lo[WIDTH-1],
                                 ~|div_lo, 1'b0};
                    ov_nxt    = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    ov_nxt    = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ir_nxt = (state_nxt == IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            bq        <= '0;
            s         <= '0;
            s2        <= '0;
            psw       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hi        <= hi_nxt;
            lo        <= lo_nxt;
            bq        <= bq_nxt;
            s         <= s_nxt;
            s2        <= s2_nxt;
            psw       <= psw_nxt;
            out_valid <= ov_nxt;
            in_ready  <= ir_nxt;
        end
    end

endmodule

// File: doc/pipe_alu.md
PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width; legal values are powers of two from 8 to 64.
REQ-002 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 A  input  WIDTH  first operand.
REQ-005 B  input  WIDTH  second operand; for shifts, B[log2(WIDTH)-1:0] is the shift amount.
REQ-006 MODE  input  4  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT(A), 6 SHL, 7 SHR (logical), 8 MUL (unsigned), 9 DIV (unsigned); 10-15 are illegal.
REQ-007 IN_VALID  input  1  A/B/MODE are valid.
REQ-008 IN_READY  output  1  the block can accept an operation.
REQ-009 S  output  WIDTH  primary result: low product for MUL, quotient for DIV.
REQ-010 S2  output  WIDTH  secondary result: high product for MUL, remainder for DIV, 0 for all other modes.
REQ-011 PSW  output  16  flags: bit0 CF, bit1 ZF, bit2 SF, bit3 OF, bit4 DZ (divide by zero), bit5 IL (illegal mode); bits 15:6 are always 0.
REQ-012 OUT_VALID  output  1  S/S2/PSW hold a result.
REQ-013 OUT_READY  input  1  the consumer takes the result.

Function
REQ-014 The FSM SHALL have the states IDLE, MUL, DIV and DONE; IN_READY SHALL be 1 only in IDLE.
REQ-015 An operation SHALL be accepted when IN_VALID and IN_READY are both 1; A, B and MODE SHALL be captured at that point, and later input changes SHALL NOT affect it.
REQ-016 Single-cycle modes (0-7, illegal modes, and DIV with B=0) SHALL go IDLE->DONE, with OUT_VALID=1 on the cycle after acceptance.
REQ-017 MUL SHALL go IDLE->MUL, run a shift-add loop for WIDTH cycles, then go to DONE; OUT_VALID SHALL rise WIDTH+1 cycles after acceptance.
REQ-018 DIV with B!=0 SHALL go IDLE->DIV, run a restoring loop for WIDTH cycles, then go to DONE; the latency SHALL be the same as MUL.
REQ-019 In DONE, S, S2, PSW and OUT_VALID SHALL hold steady while OUT_READY=0; when OUT_READY=1 the FSM SHALL go DONE->IDLE and OUT_VALID SHALL be 0 on the next cycle.
REQ-020 ADD: S=(A+B) mod 2^WIDTH; CF=carry out; OF=signed overflow.
REQ-021 SUB: S=(A-B) mod 2^WIDTH; CF=borrow (A<B unsigned); OF=signed overflow.
REQ-022 AND, OR, XOR and NOT SHALL produce CF=0 and OF=0.
REQ-023 SHL/SHR: CF=last bit shifted out, or 0 if the shift amount is 0; OF=0.
REQ-024 MUL: {S2,S}=A*B, full 2*WIDTH bits; CF=OF=(S2!=0).
REQ-025 DIV: S=A/B and S2=A%B; CF=OF=0.
REQ-026 DIV with B=0: S=all ones, S2=A, DZ=1, ZF=0, SF=S[WIDTH-1].
REQ-027 Illegal mode: S=0, S2=0, IL=1; all other flags SHALL be 0.
REQ-028 For all modes except illegal: ZF=(S==0), except for MUL where ZF=({S2,S}==0); SF=S[WIDTH-1].
REQ-029 DZ SHALL be 0 except for DIV with B=0; IL SHALL be 0 except for illegal modes.
REQ-030 The iteration counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during a loop.
REQ-031 IN_VALID asserted while busy SHALL be ignored; the operation is not queued, and the producer holds it until IN_READY=1.

Reset
REQ-032 While RST_N=0 the block SHALL be in IDLE, with S=0, S2=0, PSW=0, OUT_VALID=0 and IN_READY=1, independent of CLK.
REQ-033 Reset asserted mid-MUL, mid-DIV or in DONE SHALL abort the operation and discard any pending result; no OUT_VALID SHALL follow release.
REQ-034 After RST_N rises, the first rising CLK edge SHALL be able to accept an operation.

Verification
REQ-035 WIDTH=64: ADD A=0x20, B=0x30 -> one cycle later S=0x50, S2=0, PSW=0; then SUB A=0x50, B=0x40 -> S=0x10; then SUB A=0x10, B=0x40 -> S=0xFFFFFFFFFFFFFFD0, CF=1, SF=1.
REQ-036 MUL A=0xFFFFFFFFFFFFFFFF, B=2 -> OUT_VALID exactly 65 cycles after accept; S=0xFFFFFFFFFFFFFFFE, S2=1, CF=OF=1.
REQ-037 DIV A=100, B=7 -> after 65 cycles S=14, S2=2, PSW=0; DIV A=5, B=0 -> one cycle later S=all ones, S2=5, DZ=1.
REQ-038 Hold OUT_READY=0 for 10 cycles after ADD 0x7FFFFFFFFFFFFFFF+1 -> S=0x8000000000000000, OF=1, SF=1 held stable and IN_READY=0 throughout; pulse OUT_READY -> OUT_VALID falls next cycle.
REQ-039 Pull RST_N low 20 cycles into a MUL -> outputs zero immediately; after release, no OUT_VALID appears; MODE=15 then gives S=0, PSW=0x0020.
REQ-040 Rerun the ADD/SUB/MUL/DIV checks with WIDTH=8: MUL 0xFF*0xFF -> S=0x01, S2=0xFE, latency 9 cycles.
